// File: rtl/trap_pc_ctrl.sv
// Trap/return PC sequencer: owns the PC mux select and PC write enable, holds MEPC/MIE/MPIE.
// Optional macro INTR_SYNC_EN puts a 2-flop synchronizer on intr (adds 2 cycles of request latency).
module trap_pc_ctrl #(
    parameter int         XLEN      = 32,
    parameter logic [2:0] SEL_MTVEC = 3'd4,
    parameter logic [2:0] SEL_MEPC  = 3'd5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            intr,
    input  logic            pc_adv,
    input  logic [2:0]      pc_src,
    input  logic [XLEN-1:0] pc_next,
    input  logic            mret,
    input  logic            csr_mie_we,
    input  logic            csr_mie_d,
    output logic [2:0]      pc_sel,
    output logic            pc_we,
    output logic [XLEN-1:0] mepc,
    output logic            mie,
    output logic            mpie,
    output logic            int_taken,
    output logic            busy
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t     state, state_d;
    logic       intr_eff;
    logic       eligible;
    logic       do_mret;
    logic [2:0] src_legal;

`ifdef INTR_SYNC_EN
    logic [1:0] intr_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) intr_sync <= 2'b00;
        else        intr_sync <= {intr_sync[0], intr};
    end

    assign intr_eff = intr_sync[1];
`else
    assign intr_eff = intr;
`endif

    // Sources 4..7 are not legal from the control unit; fold them onto source 0.
    assign src_legal = pc_src[2] ? 3'd0 : pc_src;
    assign eligible  = intr_eff & mie & pc_adv & (state == RUN);
    assign do_mret   = (state == RUN) & mret & pc_adv & ~eligible;

    always_comb begin
        state_d   = state;
        pc_sel    = src_legal;
        pc_we     = pc_adv;
        int_taken = 1'b0;
        busy      = 1'b0;
        case (state)
            RUN: begin
                if (eligible) begin
                    pc_we   = 1'b0;
                    state_d = TRAP;
                end else if (do_mret) begin
                    pc_sel = SEL_MEPC;
                    pc_we  = 1'b1;
                end
            end
            TRAP: begin
                pc_sel    = SEL_MTVEC;
                pc_we     = 1'b1;
                int_taken = 1'b1;
                busy      = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
        // Keep the PC register from loading while reset is held.
        if (!rst_n) begin
            pc_sel = 3'd0;
            pc_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            mepc  <= '0;
            mie   <= 1'b0;
            mpie  <= 1'b0;
        end else begin
            state <= state_d;
            if (eligible) begin
                mepc <= pc_next;
                mpie <= mie;
                mie  <= 1'b0;
            end else if (do_mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (csr_mie_we) begin
                mie  <= csr_mie_d;
            end
        end
    end

endmodule

// File: tb/tb_trap_pc_ctrl.sv
// Scoreboarded random bench for trap_pc_ctrl; expected per-cycle outputs come from a behavioural model.
module tb_trap_pc_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            intr = 1'b0, pc_adv = 1'b0, mret = 1'b0;
    logic            csr_mie_we = 1'b0, csr_mie_d = 1'b0;
    logic [2:0]      pc_src = '0;
    logic [XLEN-1:0] pc_next = '0;
    logic [2:0]      pc_sel;
    logic            pc_we, mie, mpie, int_taken, busy;
    logic [XLEN-1:0] mepc;

    trap_pc_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .intr(intr), .pc_adv(pc_adv), .pc_src(pc_src),
        .pc_next(pc_next), .mret(mret), .csr_mie_we(csr_mie_we), .csr_mie_d(csr_mie_d),
        .pc_sel(pc_sel), .pc_we(pc_we), .mepc(mepc), .mie(mie), .mpie(mpie),
        .int_taken(int_taken), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]      sel;
        logic            we;
        logic            taken;
        logic            busy;
        logic [XLEN-1:0] mepc;
        logic            mie;
        logic            mpie;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_taken = 0;

    // Reference model state: architectural trap registers plus "redirect owed next cycle".
    bit              m_redirect;
    logic [XLEN-1:0] m_mepc;
    bit              m_mie, m_mpie;
    bit              intr_hist[2];   // [0] = previous cycle, [1] = two cycles ago

    function automatic void chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, want);
        end
    endfunction

    function automatic void model_reset();
        m_redirect = 0; m_mepc = '0; m_mie = 0; m_mpie = 0;
        intr_hist[0] = 0; intr_hist[1] = 0;
    endfunction

    // Drive one cycle of inputs, predict the outputs for that cycle and advance the model.
    task automatic step(input bit i_intr, input bit i_adv, input int i_src,
                        input logic [XLEN-1:0] i_next, input bit i_mret,
                        input bit i_we, input bit i_d);
        exp_t e;
        bit   req, take;
        int   legal_src;
        @(posedge clk); #1;
        intr = i_intr; pc_adv = i_adv; pc_src = 3'(i_src); pc_next = i_next;
        mret = i_mret; csr_mie_we = i_we; csr_mie_d = i_d;
`ifdef INTR_SYNC_EN
        req = intr_hist[1];
`else
        req = i_intr;
`endif
        legal_src = (i_src >= 0 && i_src <= 3) ? i_src : 0;
        e.mepc = m_mepc; e.mie = m_mie; e.mpie = m_mpie;
        e.taken = m_redirect; e.busy = m_redirect;
        if (m_redirect) begin
            e.sel = 3'd4; e.we = 1'b1;
            m_redirect = 0;
            if (i_we) m_mie = i_d;
        end else begin
            take = req && m_mie && i_adv;
            if (take) begin
                e.sel = 3'(legal_src); e.we = 1'b0;
                m_mepc = i_next; m_mpie = m_mie; m_mie = 0; m_redirect = 1;
            end else if (i_mret && i_adv) begin
                e.sel = 3'd5; e.we = 1'b1;
                m_mie = m_mpie; m_mpie = 1;
            end else begin
                e.sel = 3'(legal_src); e.we = i_adv;
                if (i_we) m_mie = i_d;
            end
        end
        intr_hist[1] = intr_hist[0];
        intr_hist[0] = i_intr;
        exp_q.push_back(e);
    endtask

    // Reset asserted asynchronously in the middle of a cycle, outputs checked while held.
    task automatic reset_check(string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        intr = 0; pc_adv = 1; pc_src = 3'd2; mret = 0; csr_mie_we = 0; csr_mie_d = 0;
        #1;
        chk({tag, ".pc_sel"}, XLEN'(pc_sel), 0);
        chk({tag, ".pc_we"}, XLEN'(pc_we), 0);
        chk({tag, ".mepc"}, mepc, 0);
        chk({tag, ".mie"}, XLEN'(mie), 0);
        chk({tag, ".mpie"}, XLEN'(mpie), 0);
        chk({tag, ".busy"}, XLEN'(busy), 0);
        chk({tag, ".int_taken"}, XLEN'(int_taken), 0);
        pc_adv = 0; pc_src = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc_sel", XLEN'(pc_sel), XLEN'(e.sel));
                chk("pc_we", XLEN'(pc_we), XLEN'(e.we));
                chk("int_taken", XLEN'(int_taken), XLEN'(e.taken));
                chk("busy", XLEN'(busy), XLEN'(e.busy));
                chk("mepc", mepc, e.mepc);
                chk("mie", XLEN'(mie), XLEN'(e.mie));
                chk("mpie", XLEN'(mpie), XLEN'(e.mpie));
                if (int_taken === 1'b1) n_taken++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t2_taken;
    int accept_at;

    initial begin
        model_reset();
        reset_check("por");

        // Normal flow with interrupts disabled: intr must never be taken.
        t2_taken = n_taken;
        for (int i = 0; i < 6; i++) step(1, 1, 2, 32'h100 + 32'(i * 4), 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t2.no_taken", 32'(n_taken - t2_taken), 0);

        // Entry: enable MIE, then hold the request through the accept.
        step(0, 0, 0, 0, 0, 1, 1);
`ifdef INTR_SYNC_EN
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
`endif
        step(1, 1, 1, 32'h0000_0104, 0, 0, 0);
        step(0, 1, 3, 32'h0000_0108, 1, 0, 0);   // redirect cycle: adv/mret ignored
        step(0, 1, 0, 32'h0000_0200, 0, 0, 0);
        chk("t3.mepc_model", m_mepc, 32'h104);

        // Return.
        step(0, 1, 0, 32'h0000_0204, 1, 0, 0);
        step(0, 1, 0, 32'h0000_0104, 0, 0, 0);
        chk("t4.mie_model", 32'(m_mie), 1);

        // Collision: accept beats MRET and the CSR write.
`ifdef INTR_SYNC_EN
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
`endif
        step(1, 1, 1, 32'h0000_0300, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a redirect.
        step(0, 0, 0, 0, 0, 1, 1);
`ifdef INTR_SYNC_EN
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
`endif
        step(1, 1, 2, 32'h0000_0400, 0, 0, 0);
        reset_check("mid_trap");
        step(0, 1, 1, 0, 0, 0, 0);

        // One-cycle pulse: accept lands 0 or 2 cycles after the pulse depending on the synchronizer.
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 32'h0000_0500, 0, 0, 0);
        accept_at = -1;
        for (int i = 0; i < 4; i++) begin
            if (accept_at < 0 && m_redirect) accept_at = i;
            step(0, 1, 0, 32'h0000_0504 + 32'(i * 4), 0, 0, 0);
        end
`ifdef INTR_SYNC_EN
        chk("t6.accept_delay", 32'(accept_at), 2);
`else
        chk("t6.accept_delay", 32'(accept_at), 0);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 70,
                 int'($urandom_range(0, 7)), $urandom, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
